// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, RAM power-up word, wait-counter width.
package dmem_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam logic [31:0] DMEM_INIT_WORD = 32'hFFFFFFFF;
  localparam int          WAIT_W         = 4;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data RAM: synchronous write, registered read (clearable), combinational debug read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic              i_rzero,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_dbg_data
);
  localparam int DEPTH = 1 << ADDR_W;

  // Power-up contents only; reset never clears storage.
  logic [31:0] r_mem [DEPTH] = '{default: DMEM_INIT_WORD};
  logic [31:0] r_rdata;

  always_ff @(posedge gclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register is the load-data hold register; it keeps its value between loads.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   r_rdata <= '0;
    else if (i_re) r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
  end

  assign o_rdata    = r_rdata;
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding req/ready/rvalid access with WAIT_CYCLES wait states.
// Optional misaligned-access check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data,
  output logic              err
);
  state_e              r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_we, r_mis, r_rvalid;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic                w_accept, w_commit, w_mis_in;
  logic                w_unused_addr;

  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis_in = (addr[1:0] != 2'b00);
`else
  assign w_mis_in = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: if (req) begin
        w_accept    = 1'b1;
        w_cnt_nxt   = WAIT_W'(WAIT_CYCLES);
        w_state_nxt = BUSY;
      end
      BUSY: if (r_cnt == '0) begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_commit;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= we;
      r_mis   <= w_mis_in;
      r_idx   <= addr[ADDR_W+1:2];
      r_wdata <= wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= w_commit & r_mis;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // A misaligned store is dropped; a misaligned load returns zero.
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .gclk       (Clk),
    .grst_n     (reset),
    .i_we       (w_commit & r_we & ~r_mis),
    .i_waddr    (r_idx),
    .i_wdata    (r_wdata),
    .i_re       (w_commit & ~r_we),
    .i_rzero    (r_mis),
    .i_raddr    (r_idx),
    .o_rdata    (rdata),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  assign ready  = (r_state == IDLE);
  assign rvalid = r_rvalid;
endmodule
